// File: rtl/param_sram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_sram_ctrl : single-port sync RAM, byte-masked writes, 1/2-cycle reads,
//                   post-reset clear sequencer.               Rev 1.0
// ---------------------------------------------------------------------------
module param_sram_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                RD_LAT   = 1,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rd,
  input  logic                  wt,
  input  logic [ADDR_W-1:0]     add,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   wmask,
  output logic [DATA_W-1:0]     dout,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / 8;

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("param_sram_ctrl: DATA_W (%0d) must be a non-zero multiple of 8", DATA_W);
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("param_sram_ctrl: RD_LAT (%0d) must be 1 or 2", RD_LAT);
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              accept;
  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  assign accept   = en & ~busy;
  assign rd_req   = accept & rd;
  assign wr_req   = accept & wt & ~rst;
  assign old_word = mem[add];

  // Merged word: masked lanes take din, the rest keep the stored bytes.
  always_comb begin
    wr_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (wmask[i]) begin
        wr_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  assign rd_word   = (RDW_MODE == 1 && wt) ? wr_word : old_word;
  assign out_valid = (RD_LAT == 2) ? pipe_valid : rd_req;
  assign out_data  = (RD_LAT == 2) ? pipe_data  : rd_word;

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR && !rst) begin
      mem[clr_ptr] <= INIT_VAL;
    end else if (wr_req) begin
      mem[add] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clr_ptr    <= '0;
      busy       <= 1'b1;
      dout       <= '0;
      rvalid     <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Second stage only matters when RD_LAT == 2; it is bypassed otherwise.
      pipe_valid <= rd_req;
      if (rd_req) begin
        pipe_data <= rd_word;
      end
      rvalid <= out_valid;
      if (out_valid) begin
        dout <= out_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_sram_ctrl.sv
`default_nettype none
// Directed bench: four 8-bit instances (RD_LAT x RDW_MODE) sharing stimulus,
// plus one 16-bit/16-entry instance with a non-zero clear value.
module tb_param_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        en8, rd8, wt8;
  logic [7:0]  add8, din8;
  logic [0:0]  wmask8;
  logic [7:0]  dout8   [4];
  logic        rvalid8 [4];
  logic        busy8   [4];
  logic        en16, rd16, wt16;
  logic [3:0]  add16;
  logic [15:0] din16, dout16;
  logic [1:0]  wmask16;
  logic        rvalid16, busy16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ra [4] = '{8'h00, 8'h01, 8'h02, 8'h14};
  logic [7:0] rdat [4] = '{8'h00, 8'h01, 8'h02, 8'h07};

  // index g: RD_LAT = 1 for g<2 else 2, RDW_MODE = g%2
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      param_sram_ctrl #(
        .DATA_W(8), .ADDR_W(8), .RD_LAT((g >= 2) ? 2 : 1), .RDW_MODE(g % 2)
      ) u_dut (
        .clk(clk), .rst(rst), .en(en8), .rd(rd8), .wt(wt8), .add(add8),
        .din(din8), .wmask(wmask8), .dout(dout8[g]), .rvalid(rvalid8[g]),
        .busy(busy8[g])
      );
    end
  endgenerate

  param_sram_ctrl #(
    .DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(16'hA5A5)
  ) u_dut16 (
    .clk(clk), .rst(rst), .en(en16), .rd(rd16), .wt(wt16), .add(add16),
    .din(din16), .wmask(wmask16), .dout(dout16), .rvalid(rvalid16),
    .busy(busy16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [7:0] a, input logic [7:0] d, input logic m);
    en8 = 1'b1; wt8 = 1'b1; rd8 = 1'b0; add8 = a; din8 = d; wmask8 = m;
    step();
    en8 = 1'b0; wt8 = 1'b0;
  endtask

  // Caller has just applied a reset edge; counts busy samples and stray rvalids.
  task automatic run_clear(input bit poke16);
    int cnt [5];
    int rvc;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    rvc = 0;
    rst = 1'b0;
    if (poke16) begin
      en16 = 1'b1; wt16 = 1'b1; rd16 = 1'b1; add16 = 4'd2;
      din16 = 16'hFFFF; wmask16 = 2'b11;
    end
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (busy8[i]) cnt[i]++;
        if (rvalid8[i]) rvc++;
      end
      if (busy16) cnt[4]++;
      if (rvalid16) rvc++;
      if (t == 10) begin
        en16 = 1'b0; wt16 = 1'b0; rd16 = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 4; i++) check($sformatf("busy_len8_%0d", i), cnt[i], 256);
    check("busy_len16", cnt[4], 16);
    check("rvalid_during_clear", rvc, 0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    en8 = 0; rd8 = 0; wt8 = 0; add8 = 0; din8 = 0; wmask8 = 0;
    en16 = 0; rd16 = 0; wt16 = 0; add16 = 0; din16 = 0; wmask16 = 0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy%0d", i), busy8[i], 1);
      check($sformatf("rst_rvalid%0d", i), rvalid8[i], 0);
      check($sformatf("rst_dout%0d", i), dout8[i], 0);
    end
    check("rst_busy16", busy16, 1);
    check("rst_dout16", dout16, 0);
    run_clear(1'b1);

    // 16-bit: every word holds the clear value, including the one poked while busy
    for (int a = 0; a < 16; a++) begin
      en16 = 1'b1; rd16 = 1'b1; add16 = 4'(a);
      step();
      check($sformatf("clr16_dout_%0d", a), dout16, 16'hA5A5);
      check($sformatf("clr16_rv_%0d", a), rvalid16, 1);
    end
    en16 = 1'b0; rd16 = 1'b0;

    // 16-bit byte mask
    en16 = 1'b1; wt16 = 1'b1; add16 = 4'd3; din16 = 16'h1234; wmask16 = 2'b11;
    step();
    din16 = 16'hABCD; wmask16 = 2'b01;
    step();
    wt16 = 1'b0; rd16 = 1'b1;
    step();
    en16 = 1'b0; rd16 = 1'b0;
    check("mask16_dout", dout16, 16'h12CD);
    check("mask16_rv", rvalid16, 1);
    step();
    check("hold16_rv", rvalid16, 0);
    check("hold16_dout", dout16, 16'h12CD);

    // 8-bit write then back-to-back read-back
    for (int j = 0; j < 4; j++) wr8(ra[j], rdat[j], 1'b1);
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        en8 = 1'b1; rd8 = 1'b1; add8 = ra[j];
      end else begin
        en8 = 1'b0; rd8 = 1'b0;
      end
      step();
      for (int i = 0; i < 4; i++) begin
        int src;
        src = j - ((i >= 2) ? 1 : 0);
        if (src >= 0 && src < 4) begin
          check($sformatf("rb_dout%0d_%0d", i, j), dout8[i], rdat[src]);
          check($sformatf("rb_rv%0d_%0d", i, j), rvalid8[i], 1);
        end else begin
          check($sformatf("rb_dout%0d_%0d", i, j), dout8[i], (src < 0) ? 8'h00 : rdat[3]);
          check($sformatf("rb_rv%0d_%0d", i, j), rvalid8[i], 0);
        end
      end
    end

    // Read-during-write to the same address
    wr8(8'd5, 8'h11, 1'b1);
    en8 = 1'b1; rd8 = 1'b1; wt8 = 1'b1; add8 = 8'd5; din8 = 8'h22; wmask8 = 1'b1;
    step();
    en8 = 1'b0; rd8 = 1'b0; wt8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rdw_dout%0d", i), dout8[i], (i % 2 == 1) ? 8'h22 : 8'h11);
      check($sformatf("rdw_rv%0d", i), rvalid8[i], 1);
    end
    check("rdw_rv2_early", rvalid8[2], 0);
    step();
    for (int i = 2; i < 4; i++) begin
      check($sformatf("rdw_dout%0d", i), dout8[i], (i % 2 == 1) ? 8'h22 : 8'h11);
      check($sformatf("rdw_rv%0d", i), rvalid8[i], 1);
    end
    check("rdw_rv0_idle", rvalid8[0], 0);

    // Zero write mask must not alter the word
    wr8(8'd5, 8'h33, 1'b0);
    en8 = 1'b1; rd8 = 1'b1; add8 = 8'd5;
    step();
    en8 = 1'b0; rd8 = 1'b0;
    check("post_rdw_dout0", dout8[0], 8'h22);
    check("post_rdw_dout1", dout8[1], 8'h22);
    step();
    check("post_rdw_dout2", dout8[2], 8'h22);
    check("post_rdw_dout3", dout8[3], 8'h22);

    // Reset while an RD_LAT=2 read is in flight
    en8 = 1'b1; rd8 = 1'b1; add8 = 8'h14;
    step();
    en8 = 1'b0; rd8 = 1'b0;
    check("inflight_dout0", dout8[0], 8'h07);
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst2_rv%0d", i), rvalid8[i], 0);
      check($sformatf("rst2_dout%0d", i), dout8[i], 0);
      check($sformatf("rst2_busy%0d", i), busy8[i], 1);
    end
    run_clear(1'b0);
    en8 = 1'b1; rd8 = 1'b1; add8 = 8'h14;
    step();
    en8 = 1'b0; rd8 = 1'b0;
    check("reclr_dout0", dout8[0], 8'h00);
    check("reclr_rv0", rvalid8[0], 1);
    step();
    check("reclr_dout2", dout8[2], 8'h00);
    check("reclr_rv2", rvalid8[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_sram_ctrl.md
Name: param_sram_ctrl

Overview:
- Parametrised single-port synchronous RAM; successor to the fixed 8-bit/256-entry sRAM in the basic processor.
- Adds configurable width and depth, per-byte write mask, selectable read latency, and a defined read-during-write mode.
- Adds a post-reset hardware clear sequencer with a busy flag and a read-valid strobe.
- Serves as data/instruction memory for the processor datapath.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, read-during-write to same address: 0 = read-first (old data), 1 = write-first (new data).
- INIT_VAL, 0, DATA_W-bit value written to every word during the clear sequence.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  request enable; request accepted at an edge where en=1 and busy=0.
- rd  in  1  read request, qualified by en.
- wt  in  1  write request, qualified by en.
- add  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- wmask  in  DATA_W/8  byte-lane write enable; bit i covers din[8i+7:8i].
- dout  out  DATA_W  read data; holds last value between reads.
- rvalid  out  1  one-cycle strobe, high in the cycle dout presents new read data.
- busy  out  1  high while the clear sequence runs; requests ignored.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= CLEAR, clr_ptr <= 0, busy <= 1, dout <= 0, rvalid <= 0.
  - Read pipeline is flushed; an in-flight read never produces rvalid.
  - This applies mid-operation and mid-clear; the clear always restarts at address 0.
- CLEAR state:
  - On each edge with rst=0: mem[clr_ptr] <= INIT_VAL, clr_ptr += 1.
  - On the edge that writes address DEPTH-1: state <= IDLE, busy <= 0.
  - busy is therefore high for exactly DEPTH cycles after the first edge with rst=0.
  - en, rd, wt, add, din and wmask are ignored throughout CLEAR.
- IDLE/operational, request accepted at edge k (en=1, busy=0):
  - Write (wt=1): each byte lane i with wmask[i]=1 gets the corresponding din byte; lanes with wmask[i]=0 are unchanged. wt=1 with wmask=0 is a no-op.
  - Read (rd=1): RD_LAT=1 updates dout and asserts rvalid after edge k. RD_LAT=2 registers the address/data once more, so dout/rvalid update after edge k+1.
  - Reads may be issued every cycle; with RD_LAT=2 the pipeline is fully overlapped (one result per cycle).
  - rd=1 and wt=1 together, same address:
    - RDW_MODE=0: dout returns pre-write contents.
    - RDW_MODE=1: dout returns the post-write word (masked bytes new, others old).
  - en=0, or rd=wt=0: no memory change; rvalid=0 next cycle; dout holds.
- Address is an unsigned word index. Every value of add is in range (no wrap beyond DEPTH, no out-of-range case).
- rvalid is never asserted while busy=1 or in the cycle after a reset edge.
- Parameter check: DATA_W%8!=0 or RD_LAT not in {1,2} triggers an elaboration-time $error.

Test Plan:
- Clear after reset (DATA_W=16, ADDR_W=4, INIT_VAL=16'hA5A5): pulse rst one cycle → busy=1 for exactly 16 cycles; then read addresses 0..15 → each returns 16'hA5A5 with rvalid one cycle later.
- Write/read-back (defaults): write 0x00@0x00, 0x01@0x01, 0x02@0x02, 0x07@0x14 with wmask=1; then read the same addresses back-to-back → dout 0x00, 0x01, 0x02, 0x07 on consecutive cycles, rvalid high for 4 cycles.
- Byte mask (DATA_W=16): write 16'h1234@3 (wmask=2'b11), then 16'hABCD@3 (wmask=2'b01); read 3 → 16'h12CD.
- Read-during-write: mem[5]=8'h11; same-cycle rd+wt to 5 with din=8'h22 → RDW_MODE=0 gives dout 8'h11, RDW_MODE=1 gives 8'h22; a subsequent read gives 8'h22 in both modes.
- Busy/reset interlock: issue a write to 2 while busy=1 → a later read of 2 returns INIT_VAL. Assert rst with an RD_LAT=2 read in flight → no rvalid, dout=0, clear restarts at address 0.
- RD_LAT=2 latency: read 0x14 (holding 0x07) at edge k → dout=0x07 and rvalid=1 only after edge k+1; dout holds 0x07 while idle afterwards.
